// File: rtl/aer_timestep_scheduler_if.sv
// aer_timestep_scheduler_if: requester-side and spike-side bus of the AER timestep scheduler
//   req_en    [NREQ]     requester enable mask, sampled at ts_start
//   req_valid [NREQ]     requester i has an event
//   req_index [NREQ*IW]  packed indices, requester i at [i*IW +: IW]
//   req_done  [NREQ]     requester i has no more events this timestep
//   req_ready [NREQ]     one-hot grant from the scheduler
//   spike_valid_out / spike_index_out [IW] / spike_last_out   merged spike stream
//   master: requester/consumer side, slave: scheduler side
interface aer_timestep_scheduler_if #(
   parameter int NREQ = 4,
   parameter int IW   = 14
);
   logic [NREQ-1:0]    req_en;
   logic [NREQ-1:0]    req_valid;
   logic [NREQ*IW-1:0] req_index;
   logic [NREQ-1:0]    req_done;
   logic [NREQ-1:0]    req_ready;
   logic               spike_valid_out;
   logic [IW-1:0]      spike_index_out;
   logic               spike_last_out;

   modport master (
      output req_en, req_valid, req_index, req_done,
      input  req_ready, spike_valid_out, spike_index_out, spike_last_out
   );

   modport slave (
      input  req_en, req_valid, req_index, req_done,
      output req_ready, spike_valid_out, spike_index_out, spike_last_out
   );
endinterface

// File: rtl/aer_timestep_scheduler.sv
// aer_timestep_scheduler: merges AER events from NREQ requesters into one per-timestep spike stream
//   clk, rst_n       clock, asynchronous active-low reset
//   ts_start         pulse: begin a timestep (accepted in IDLE only)
//   bus (slave)      requester handshake in, spike stream out (see aer_timestep_scheduler_if)
//   ts_busy          high in RUN/FLUSH
//   ts_done          one-cycle pulse: timestep complete
//   ts_empty         one-cycle pulse with ts_done: no events this timestep
//   ts_event_count   events emitted this timestep, saturating
//   idx_err          one-cycle pulse: out-of-range index dropped
// Optional feature: define AER_RANGE_CHECK_EN to drop events with index >= N_SYNAPSE.
module aer_timestep_scheduler #(
   parameter int NREQ      = 4,
   parameter int IW        = 14,
   parameter int N_SYNAPSE = 10000,
   parameter int CW        = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ts_start,
   aer_timestep_scheduler_if.slave bus,
   output logic                    ts_busy,
   output logic                    ts_done,
   output logic                    ts_empty,
   output logic [CW-1:0]           ts_event_count,
   output logic                    idx_err
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef AER_RANGE_CHECK_EN
   localparam bit RCHK = 1'b1;
`else
   localparam bit RCHK = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t          state_q, state_d;
   logic [NREQ-1:0] mask_q, mask_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic            hold_valid_q, hold_valid_d;
   logic [IW-1:0]   hold_index_q, hold_index_d;
   logic            spike_valid_q, spike_valid_d;
   logic [IW-1:0]   spike_index_q, spike_index_d;
   logic            spike_last_q, spike_last_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            empty_q, empty_d;

   logic [NREQ-1:0] cand;
   logic [PW-1:0]   gidx, p;
   logic            any_grant, all_done, bad;
   logic [IW-1:0]   gindex;

   assign cand     = bus.req_valid & mask_q & {NREQ{state_q == RUN}};
   assign all_done = (&(bus.req_done | ~mask_q)) && !(|(bus.req_valid & mask_q));

   // Walk from the farthest slot back toward the pointer so the candidate
   // closest to the pointer (searching upward with wrap) is the last one written.
   always_comb begin
      gidx      = '0;
      p         = '0;
      any_grant = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         p = PW'((int'(ptr_q) + k) % NREQ);
         if (cand[p]) begin
            gidx      = p;
            any_grant = 1'b1;
         end
      end
   end

   assign gindex        = bus.req_index[int'(gidx)*IW +: IW];
   assign bad           = RCHK && any_grant && (int'(gindex) >= N_SYNAPSE);
   assign bus.req_ready = any_grant ? (NREQ'(1) << gidx) : '0;

   always_comb begin
      state_d       = state_q;
      mask_d        = mask_q;
      ptr_d         = ptr_q;
      hold_valid_d  = hold_valid_q;
      hold_index_d  = hold_index_q;
      spike_valid_d = 1'b0;
      spike_index_d = '0;
      spike_last_d  = 1'b0;
      empty_d       = 1'b0;
      cnt_d         = cnt_q;
      case (state_q)
         IDLE: if (ts_start) begin
            state_d      = RUN;
            mask_d       = bus.req_en;
            cnt_d        = '0;
            hold_valid_d = 1'b0;
         end
         RUN: if (any_grant) begin
            ptr_d = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
            // A full hold is pushed out as a non-final spike when a new good event replaces it.
            if (!bad) begin
               spike_valid_d = hold_valid_q;
               spike_index_d = hold_valid_q ? hold_index_q : '0;
               hold_valid_d  = 1'b1;
               hold_index_d  = gindex;
            end
         end else if (all_done) begin
            state_d = FLUSH;
         end
         FLUSH: begin
            spike_valid_d = hold_valid_q;
            spike_last_d  = hold_valid_q;
            spike_index_d = hold_valid_q ? hold_index_q : '0;
            empty_d       = !hold_valid_q;
            hold_valid_d  = 1'b0;
            state_d       = DONE;
         end
         default: state_d = IDLE;
      endcase
      // Counted alongside the output register so the count already includes the final spike at ts_done.
      if (spike_valid_d && !(&cnt_q))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         mask_q        <= '0;
         ptr_q         <= '0;
         hold_valid_q  <= 1'b0;
         hold_index_q  <= '0;
         spike_valid_q <= 1'b0;
         spike_index_q <= '0;
         spike_last_q  <= 1'b0;
         cnt_q         <= '0;
         empty_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         mask_q        <= mask_d;
         ptr_q         <= ptr_d;
         hold_valid_q  <= hold_valid_d;
         hold_index_q  <= hold_index_d;
         spike_valid_q <= spike_valid_d;
         spike_index_q <= spike_index_d;
         spike_last_q  <= spike_last_d;
         cnt_q         <= cnt_d;
         empty_q       <= empty_d;
      end
   end

   assign bus.spike_valid_out = spike_valid_q;
   assign bus.spike_index_out = spike_index_q;
   assign bus.spike_last_out  = spike_last_q;
   assign ts_busy             = (state_q == RUN) || (state_q == FLUSH);
   assign ts_done             = (state_q == DONE);
   assign ts_empty            = empty_q;
   assign ts_event_count      = cnt_q;
   assign idx_err             = bad;
endmodule

// File: tb/tb_aer_timestep_scheduler.sv
// tb_aer_timestep_scheduler: table-driven per-cycle vectors plus directed reset/saturation/range sequences
module tb_aer_timestep_scheduler;
   localparam int NREQ = 4;
   localparam int IW   = 14;
   localparam int CW   = 4;
   localparam int OW   = 28;
`ifdef AER_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif
   localparam logic [55:0] IX2 = {14'd103, 14'd102, 14'd101, 14'd100};
   localparam logic [55:0] IX4 = {14'd0, 14'd7, 14'd0, 14'd50};
   localparam logic [55:0] NIX = '0;

   typedef struct {
      logic          st;
      logic [3:0]    en;
      logic [3:0]    v;
      logic [3:0]    dn;
      logic [55:0]   idx;
      logic [OW-1:0] exp;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic ts_start;
   logic ts_busy, ts_done, ts_empty, idx_err;
   logic [CW-1:0] ts_event_count;
   int nvec = 0;
   int nerr = 0;
   vec_t tbl[$];

   aer_timestep_scheduler_if #(.NREQ(NREQ), .IW(IW)) bus ();

   aer_timestep_scheduler #(.NREQ(NREQ), .IW(IW), .N_SYNAPSE(10000), .CW(CW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ts_start(ts_start),
      .bus(bus),
      .ts_busy(ts_busy),
      .ts_done(ts_done),
      .ts_empty(ts_empty),
      .ts_event_count(ts_event_count),
      .idx_err(idx_err)
   );

   always #5 clk = ~clk;

   function automatic logic [OW-1:0] ex(logic [3:0] rdy, logic sv, logic [13:0] si, logic sl,
                                        logic busy, logic dno, logic emp, logic [3:0] cnt, logic err);
      return {rdy, sv, si, sl, busy, dno, emp, cnt, err};
   endfunction

   function automatic vec_t mk(logic st, logic [3:0] en, logic [3:0] v, logic [3:0] dn,
                               logic [55:0] idx, logic [OW-1:0] e);
      vec_t r;
      r.st = st; r.en = en; r.v = v; r.dn = dn; r.idx = idx; r.exp = e;
      return r;
   endfunction

   function automatic logic [OW-1:0] outs();
      return {bus.req_ready, bus.spike_valid_out, bus.spike_index_out, bus.spike_last_out,
              ts_busy, ts_done, ts_empty, ts_event_count, idx_err};
   endfunction

   task automatic drive(input logic st, input logic [3:0] en, input logic [3:0] v,
                        input logic [3:0] dn, input logic [55:0] idx);
      ts_start      = st;
      bus.req_en    = en;
      bus.req_valid = v;
      bus.req_done  = dn;
      bus.req_index = idx;
   endtask

   task automatic chk(input string nm, input logic [OW-1:0] got, input logic [OW-1:0] want);
      nvec++;
      if (got !== want) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (rdy,sv,idx,last,busy,done,empty,cnt,err)", nm, got, want);
      end
   endtask

   initial begin
      // T2 fairness from pointer 0: grants 0,1,2,3,0
      tbl.push_back(mk('1, 4'hf, 4'h0, 4'h0, IX2, ex(4'h0, '0, 14'd0,   '0, '0, '0, '0, 4'd0, '0)));
      tbl.push_back(mk('0, 4'hf, 4'hf, 4'h0, IX2, ex(4'h1, '0, 14'd0,   '0, '1, '0, '0, 4'd0, '0)));
      tbl.push_back(mk('0, 4'hf, 4'hf, 4'h0, IX2, ex(4'h2, '0, 14'd0,   '0, '1, '0, '0, 4'd0, '0)));
      tbl.push_back(mk('0, 4'hf, 4'hf, 4'h0, IX2, ex(4'h4, '1, 14'd100, '0, '1, '0, '0, 4'd1, '0)));
      tbl.push_back(mk('0, 4'hf, 4'hf, 4'h0, IX2, ex(4'h8, '1, 14'd101, '0, '1, '0, '0, 4'd2, '0)));
      tbl.push_back(mk('0, 4'hf, 4'hf, 4'h0, IX2, ex(4'h1, '1, 14'd102, '0, '1, '0, '0, 4'd3, '0)));
      tbl.push_back(mk('0, 4'hf, 4'h0, 4'hf, IX2, ex(4'h0, '1, 14'd103, '0, '1, '0, '0, 4'd4, '0)));
      tbl.push_back(mk('0, 4'hf, 4'h0, 4'hf, IX2, ex(4'h0, '0, 14'd0,   '0, '1, '0, '0, 4'd4, '0)));
      tbl.push_back(mk('0, 4'hf, 4'h0, 4'hf, IX2, ex(4'h0, '1, 14'd100, '1, '0, '1, '0, 4'd5, '0)));
      // T1 single requester: 5, 9, 12(last)
      tbl.push_back(mk('1, 4'h1, 4'h0, 4'h0, NIX, ex(4'h0, '0, 14'd0,  '0, '0, '0, '0, 4'd5, '0)));
      tbl.push_back(mk('0, 4'h1, 4'h1, 4'h0, {42'd0, 14'd5},  ex(4'h1, '0, 14'd0, '0, '1, '0, '0, 4'd0, '0)));
      tbl.push_back(mk('0, 4'h1, 4'h1, 4'h0, {42'd0, 14'd9},  ex(4'h1, '0, 14'd0, '0, '1, '0, '0, 4'd0, '0)));
      tbl.push_back(mk('0, 4'h1, 4'h1, 4'h0, {42'd0, 14'd12}, ex(4'h1, '1, 14'd5, '0, '1, '0, '0, 4'd1, '0)));
      tbl.push_back(mk('0, 4'h1, 4'h0, 4'h1, NIX, ex(4'h0, '1, 14'd9,  '0, '1, '0, '0, 4'd2, '0)));
      tbl.push_back(mk('0, 4'h1, 4'h0, 4'h1, NIX, ex(4'h0, '0, 14'd0,  '0, '1, '0, '0, 4'd2, '0)));
      tbl.push_back(mk('0, 4'h1, 4'h0, 4'h1, NIX, ex(4'h0, '1, 14'd12, '1, '0, '1, '0, 4'd3, '0)));
      tbl.push_back(mk('0, 4'h1, 4'h0, 4'h0, NIX, ex(4'h0, '0, 14'd0,  '0, '0, '0, '0, 4'd3, '0)));
      // T3 empty timestep
      tbl.push_back(mk('1, 4'hf, 4'h0, 4'hf, NIX, ex(4'h0, '0, 14'd0, '0, '0, '0, '0, 4'd3, '0)));
      tbl.push_back(mk('0, 4'hf, 4'h0, 4'hf, NIX, ex(4'h0, '0, 14'd0, '0, '1, '0, '0, 4'd0, '0)));
      tbl.push_back(mk('0, 4'hf, 4'h0, 4'hf, NIX, ex(4'h0, '0, 14'd0, '0, '1, '0, '0, 4'd0, '0)));
      tbl.push_back(mk('0, 4'hf, 4'h0, 4'hf, NIX, ex(4'h0, '0, 14'd0, '0, '0, '1, '1, 4'd0, '0)));
      tbl.push_back(mk('0, 4'hf, 4'h0, 4'h0, NIX, ex(4'h0, '0, 14'd0, '0, '0, '0, '0, 4'd0, '0)));
      // T4 done+valid together on req 2, masked req 0 valid is never granted
      tbl.push_back(mk('1, 4'h4, 4'h0, 4'h0, IX4, ex(4'h0, '0, 14'd0, '0, '0, '0, '0, 4'd0, '0)));
      tbl.push_back(mk('0, 4'h4, 4'h5, 4'h4, IX4, ex(4'h4, '0, 14'd0, '0, '1, '0, '0, 4'd0, '0)));
      tbl.push_back(mk('0, 4'h4, 4'h1, 4'h4, IX4, ex(4'h0, '0, 14'd0, '0, '1, '0, '0, 4'd0, '0)));
      tbl.push_back(mk('0, 4'h4, 4'h1, 4'h4, IX4, ex(4'h0, '0, 14'd0, '0, '1, '0, '0, 4'd0, '0)));
      tbl.push_back(mk('0, 4'h4, 4'h0, 4'h4, IX4, ex(4'h0, '1, 14'd7, '1, '0, '1, '0, 4'd1, '0)));
      // mask 0 with valids everywhere, ts_start during RUN ignored
      tbl.push_back(mk('1, 4'h0, 4'hf, 4'h0, IX2, ex(4'h0, '0, 14'd0, '0, '0, '0, '0, 4'd1, '0)));
      tbl.push_back(mk('1, 4'h0, 4'hf, 4'h0, IX2, ex(4'h0, '0, 14'd0, '0, '1, '0, '0, 4'd0, '0)));
      tbl.push_back(mk('0, 4'h0, 4'hf, 4'h0, IX2, ex(4'h0, '0, 14'd0, '0, '1, '0, '0, 4'd0, '0)));
      tbl.push_back(mk('0, 4'h0, 4'hf, 4'h0, IX2, ex(4'h0, '0, 14'd0, '0, '0, '1, '1, 4'd0, '0)));
      tbl.push_back(mk('0, 4'h0, 4'h0, 4'h0, NIX, ex(4'h0, '0, 14'd0, '0, '0, '0, '0, 4'd0, '0)));
      // wrap: pointer at 3, requesters 0 and 2 valid -> grants 0 then 2
      tbl.push_back(mk('1, 4'hf, 4'h0, 4'h0, IX2, ex(4'h0, '0, 14'd0,   '0, '0, '0, '0, 4'd0, '0)));
      tbl.push_back(mk('0, 4'hf, 4'h5, 4'h0, IX2, ex(4'h1, '0, 14'd0,   '0, '1, '0, '0, 4'd0, '0)));
      tbl.push_back(mk('0, 4'hf, 4'h5, 4'h0, IX2, ex(4'h4, '0, 14'd0,   '0, '1, '0, '0, 4'd0, '0)));
      tbl.push_back(mk('0, 4'hf, 4'h0, 4'hf, IX2, ex(4'h0, '1, 14'd100, '0, '1, '0, '0, 4'd1, '0)));
      tbl.push_back(mk('0, 4'hf, 4'h0, 4'hf, IX2, ex(4'h0, '0, 14'd0,   '0, '1, '0, '0, 4'd1, '0)));
      tbl.push_back(mk('0, 4'hf, 4'h0, 4'hf, IX2, ex(4'h0, '1, 14'd102, '1, '0, '1, '0, 4'd2, '0)));

      rst_n = 1'b0;
      drive('0, 4'h0, 4'h0, 4'h0, NIX);
      #1 chk("reset", outs(), '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      for (int k = 0; k < tbl.size(); k++) begin
         drive(tbl[k].st, tbl[k].en, tbl[k].v, tbl[k].dn, tbl[k].idx);
         #1 chk($sformatf("vec%0d", k), outs(), tbl[k].exp);
         @(negedge clk);
      end

      // T5: ts_start in RUN ignored, then reset mid-RUN with an event in hold
      drive('1, 4'h1, 4'h0, 4'h0, NIX);
      @(negedge clk);
      drive('0, 4'h1, 4'h1, 4'h0, {42'd0, 14'd21});
      @(negedge clk);
      drive('0, 4'h1, 4'h1, 4'h0, {42'd0, 14'd22});
      @(negedge clk);
      drive('1, 4'h1, 4'h0, 4'h0, NIX);
      #1 chk("t5_run", outs(), ex(4'h0, '1, 14'd21, '0, '1, '0, '0, 4'd1, '0));
      @(negedge clk);
      drive('0, 4'h1, 4'h0, 4'h0, NIX);
      #1 chk("t5_start_ignored", outs(), ex(4'h0, '0, 14'd0, '0, '1, '0, '0, 4'd1, '0));
      drive('0, 4'h1, 4'h1, 4'h0, {42'd0, 14'd23});
      rst_n = 1'b0;
      #1 chk("t5_reset", outs(), '0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1 chk("t5_idle", outs(), '0);
         @(negedge clk);
      end
      drive('1, 4'h1, 4'h0, 4'h1, NIX);
      @(negedge clk);
      drive('0, 4'h1, 4'h0, 4'h1, NIX);
      repeat (2) @(negedge clk);
      #1 chk("t5_after_reset_empty", outs(), ex(4'h0, '0, 14'd0, '0, '0, '1, '1, 4'd0, '0));
      @(negedge clk);

      // Counter saturation at all-ones (CW=4): 18 events
      drive('1, 4'h1, 4'h0, 4'h0, NIX);
      @(negedge clk);
      for (int i = 0; i < 18; i++) begin
         drive('0, 4'h1, 4'h1, 4'h0, {42'd0, 14'(200 + i)});
         @(negedge clk);
      end
      drive('0, 4'h1, 4'h0, 4'h1, NIX);
      repeat (2) @(negedge clk);
      #1 chk("sat_done", outs(), ex(4'h0, '1, 14'd217, '1, '0, '1, '0, 4'd15, '0));
      @(negedge clk);

      // T6: indices 9999, 10000, 3
      drive('1, 4'h1, 4'h0, 4'h0, NIX);
      @(negedge clk);
      drive('0, 4'h1, 4'h1, 4'h0, {42'd0, 14'd9999});
      #1 chk("t6_a", outs(), ex(4'h1, '0, 14'd0, '0, '1, '0, '0, 4'd0, '0));
      @(negedge clk);
      drive('0, 4'h1, 4'h1, 4'h0, {42'd0, 14'd10000});
      #1 chk("t6_b", outs(), ex(4'h1, '0, 14'd0, '0, '1, '0, '0, 4'd0, RC));
      @(negedge clk);
      drive('0, 4'h1, 4'h1, 4'h0, {42'd0, 14'd3});
      #1 chk("t6_c", outs(), ex(4'h1, !RC, RC ? 14'd0 : 14'd9999, '0, '1, '0, '0, RC ? 4'd0 : 4'd1, '0));
      @(negedge clk);
      drive('0, 4'h1, 4'h0, 4'h1, NIX);
      #1 chk("t6_d", outs(), ex(4'h0, '1, RC ? 14'd9999 : 14'd10000, '0, '1, '0, '0, RC ? 4'd1 : 4'd2, '0));
      @(negedge clk);
      #1 chk("t6_flush", outs(), ex(4'h0, '0, 14'd0, '0, '1, '0, '0, RC ? 4'd1 : 4'd2, '0));
      @(negedge clk);
      #1 chk("t6_done", outs(), ex(4'h0, '1, 14'd3, '1, '0, '1, '0, RC ? 4'd2 : 4'd3, '0));
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
